// File: rtl/program_counter_core_if.sv
// Command and status bundle between the preset mux / fetch side and the program counter.
// The master drives the commands and the preset value; the slave (the counter) drives status.
interface program_counter_core_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] preset;
    logic             load;
    logic             call;
    logic             ret;
    logic             inc_en;
    logic             clr_err;
    logic [WIDTH-1:0] pc;
    logic             stack_empty;
    logic             stack_full;
    logic             ovf_err;
    logic             unf_err;
    logic             wrap;

    modport master (
        output preset, load, call, ret, inc_en, clr_err,
        input  pc, stack_empty, stack_full, ovf_err, unf_err, wrap
    );

    modport slave (
        input  preset, load, call, ret, inc_en, clr_err,
        output pc, stack_empty, stack_full, ovf_err, unf_err, wrap
    );
endinterface

// File: rtl/program_counter_core.sv
// Program counter with hold/increment/load and call/return through a small LIFO
// return-address stack; sticky overflow/underflow flags and a one-cycle wrap pulse.
module program_counter_core #(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = {WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    program_counter_core_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        CMD_HOLD = 3'd0,
        CMD_LOAD = 3'd1,
        CMD_CALL = 3'd2,
        CMD_RET  = 3'd3,
        CMD_INC  = 3'd4
    } cmd_e;

    logic [WIDTH-1:0] stack_r [DEPTH];
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_s;
    logic [WIDTH-1:0] pc_inc_s;
    logic             ovf_r;
    logic             ovf_s;
    logic             unf_r;
    logic             unf_s;
    logic             wrap_r;
    logic             wrap_s;
    logic             push_s;
    logic             full_s;
    logic             empty_s;
    logic [AW-1:0]    push_idx_s;
    logic [AW-1:0]    top_idx_s;
    cmd_e             cmd_s;

    assign full_s     = (count_r == CW'(DEPTH));
    assign empty_s    = (count_r == {CW{1'b0}});
    assign pc_inc_s   = pc_r + {{(WIDTH-1){1'b0}}, 1'b1};
    // count_r < DEPTH whenever a push happens, so the narrowed index is always in range.
    assign push_idx_s = AW'(count_r);
    assign top_idx_s  = AW'(count_r - CW'(1));

    // Priority decode of the command inputs: load > call > ret > inc_en > hold.
    always_comb begin
        cmd_s = CMD_HOLD;
        if (bus.load) begin
            cmd_s = CMD_LOAD;
        end else if (bus.call) begin
            cmd_s = CMD_CALL;
        end else if (bus.ret) begin
            cmd_s = CMD_RET;
        end else if (bus.inc_en) begin
            cmd_s = CMD_INC;
        end else begin
            cmd_s = CMD_HOLD;
        end
    end

    // Next-state for pc, stack depth and flags; a new error event overrides clr_err.
    always_comb begin
        pc_s    = pc_r;
        count_s = count_r;
        push_s  = 1'b0;
        wrap_s  = 1'b0;
        if (bus.clr_err) begin
            ovf_s = 1'b0;
            unf_s = 1'b0;
        end else begin
            ovf_s = ovf_r;
            unf_s = unf_r;
        end
        case (cmd_s)
            CMD_LOAD: pc_s = bus.preset;
            CMD_CALL: begin
                if (full_s) begin
                    ovf_s = 1'b1;
                end else begin
                    push_s  = 1'b1;
                    count_s = count_r + CW'(1);
                    pc_s    = bus.preset;
                end
            end
            CMD_RET: begin
                if (empty_s) begin
                    unf_s = 1'b1;
                end else begin
                    count_s = count_r - CW'(1);
                    pc_s    = stack_r[top_idx_s];
                end
            end
            CMD_INC: begin
                pc_s   = pc_inc_s;
                wrap_s = &pc_r;
            end
            CMD_HOLD: pc_s = pc_r;
            default:  pc_s = pc_r;
        endcase
    end

    // State registers, including the return-address stack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= RESET_VEC;
            count_r <= {CW{1'b0}};
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
            wrap_r  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            pc_r    <= pc_s;
            count_r <= count_s;
            ovf_r   <= ovf_s;
            unf_r   <= unf_s;
            wrap_r  <= wrap_s;
            if (push_s) begin
                stack_r[push_idx_s] <= pc_inc_s;
            end
        end
    end

    assign bus.pc          = pc_r;
    assign bus.stack_empty = empty_s;
    assign bus.stack_full  = full_s;
    assign bus.ovf_err     = ovf_r;
    assign bus.unf_err     = unf_r;
    assign bus.wrap        = wrap_r;
endmodule

// File: tb/tb_program_counter_core.sv
// Scoreboard bench for program_counter_core: expected observations are queued as each
// command is driven and popped for comparison one cycle later.
module tb_program_counter_core;
    logic clk;
    logic rst_n;

    program_counter_core_if #(.WIDTH(16)) bus ();

    program_counter_core #(.WIDTH(16), .DEPTH(4), .RESET_VEC(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // obs flags: {empty, full, ovf, unf, wrap}; cmd flags: {load, call, ret, inc_en, clr_err}
    typedef struct packed {
        logic [15:0] pc;
        logic [4:0]  fl;
    } obs_t;

    typedef struct packed {
        logic [15:0] preset;
        logic [4:0]  fl;
    } cmd_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t ob(input logic [15:0] pc, input logic [4:0] fl);
        obs_t o;
        o.pc = pc;
        o.fl = fl;
        return o;
    endfunction

    function automatic cmd_t cm(input logic [15:0] preset, input logic [4:0] fl);
        cmd_t c;
        c.preset = preset;
        c.fl     = fl;
        return c;
    endfunction

    function automatic obs_t sample();
        return ob(bus.pc, {bus.stack_empty, bus.stack_full, bus.ovf_err, bus.unf_err, bus.wrap});
    endfunction

    task automatic apply(input cmd_t c);
        bus.preset  = c.preset;
        bus.load    = c.fl[4];
        bus.call    = c.fl[3];
        bus.ret     = c.fl[2];
        bus.inc_en  = c.fl[1];
        bus.clr_err = c.fl[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got;
        obs_t want;
        apply(cm(16'h1234, 5'b10000));
        tick();
        apply(cm(16'h0077, 5'b01000));
        tick();
        apply(cm(16'h0000, 5'b00000));
        #3;
        rst_n = 1'b0;
        exp_q.push_back(ob(16'h0000, 5'b10000));
        #1;
        got  = sample();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_async: got pc=%h fl=%b want pc=%h fl=%b", got.pc, got.fl, want.pc, want.fl);
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ob(16'h0000, 5'b10000));
            tick();
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_hold step %0d: got pc=%h fl=%b want pc=%h fl=%b", i, got.pc, got.fl, want.pc, want.fl);
            end
        end
    endtask

    task automatic test_load_inc();
        cmd_t c[6];
        obs_t e[6];
        obs_t got;
        obs_t want;
        c = '{cm(16'd34, 5'b10000), cm(16'd0, 5'b00010), cm(16'd0, 5'b00010),
              cm(16'd0, 5'b00010), cm(16'd54, 5'b10010), cm(16'd60, 5'b11000)};
        e = '{ob(16'd34, 5'b10000), ob(16'd35, 5'b10000), ob(16'd36, 5'b10000),
              ob(16'd37, 5'b10000), ob(16'd54, 5'b10000), ob(16'd60, 5'b10000)};
        foreach (c[i]) begin
            apply(c[i]);
            exp_q.push_back(e[i]);
            tick();
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL load_inc step %0d: got pc=%0d fl=%b want pc=%0d fl=%b", i, got.pc, got.fl, want.pc, want.fl);
            end
        end
    endtask

    task automatic test_call_ret();
        cmd_t c[5];
        obs_t e[5];
        obs_t got;
        obs_t want;
        c = '{cm(16'd10, 5'b10000), cm(16'd100, 5'b01000), cm(16'd200, 5'b01000),
              cm(16'd0, 5'b00110), cm(16'd0, 5'b00100)};
        e = '{ob(16'd10, 5'b10000), ob(16'd100, 5'b00000), ob(16'd200, 5'b00000),
              ob(16'd101, 5'b00000), ob(16'd11, 5'b10000)};
        foreach (c[i]) begin
            apply(c[i]);
            exp_q.push_back(e[i]);
            tick();
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL call_ret step %0d: got pc=%0d fl=%b want pc=%0d fl=%b", i, got.pc, got.fl, want.pc, want.fl);
            end
        end
    endtask

    task automatic test_overflow();
        cmd_t c[15];
        obs_t e[15];
        obs_t got;
        obs_t want;
        c = '{cm(16'd1000, 5'b01000), cm(16'd1100, 5'b01000), cm(16'd1200, 5'b01000),
              cm(16'd1300, 5'b01000), cm(16'd500, 5'b01000), cm(16'd0, 5'b00100),
              cm(16'd0, 5'b00001), cm(16'd1400, 5'b01000), cm(16'd600, 5'b01001),
              cm(16'd0, 5'b00001), cm(16'd0, 5'b00100), cm(16'd0, 5'b00100),
              cm(16'd0, 5'b00100), cm(16'd0, 5'b00100), cm(16'd0, 5'b00000)};
        e = '{ob(16'd1000, 5'b00000), ob(16'd1100, 5'b00000), ob(16'd1200, 5'b00000),
              ob(16'd1300, 5'b01000), ob(16'd1300, 5'b01100), ob(16'd1201, 5'b00100),
              ob(16'd1201, 5'b00000), ob(16'd1400, 5'b01000), ob(16'd1400, 5'b01100),
              ob(16'd1400, 5'b01000), ob(16'd1202, 5'b00000), ob(16'd1101, 5'b00000),
              ob(16'd1001, 5'b00000), ob(16'd12, 5'b10000), ob(16'd12, 5'b10000)};
        foreach (c[i]) begin
            apply(c[i]);
            exp_q.push_back(e[i]);
            tick();
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL overflow step %0d: got pc=%0d fl=%b want pc=%0d fl=%b", i, got.pc, got.fl, want.pc, want.fl);
            end
        end
    endtask

    task automatic test_underflow_wrap();
        cmd_t c[10];
        obs_t e[10];
        obs_t got;
        obs_t want;
        c = '{cm(16'd0, 5'b00110), cm(16'd0, 5'b00101), cm(16'd0, 5'b00001),
              cm(16'hFFFF, 5'b10000), cm(16'd0, 5'b00010), cm(16'd0, 5'b00010),
              cm(16'd0, 5'b00000), cm(16'hFFFF, 5'b10000), cm(16'd7, 5'b01000),
              cm(16'd0, 5'b00100)};
        e = '{ob(16'd12, 5'b10010), ob(16'd12, 5'b10010), ob(16'd12, 5'b10000),
              ob(16'hFFFF, 5'b10000), ob(16'd0, 5'b10001), ob(16'd1, 5'b10000),
              ob(16'd1, 5'b10000), ob(16'hFFFF, 5'b10000), ob(16'd7, 5'b00000),
              ob(16'd0, 5'b10000)};
        foreach (c[i]) begin
            apply(c[i]);
            exp_q.push_back(e[i]);
            tick();
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL underflow_wrap step %0d: got pc=%h fl=%b want pc=%h fl=%b", i, got.pc, got.fl, want.pc, want.fl);
            end
        end
    endtask

    task automatic test_reset_mid_call();
        obs_t got;
        obs_t want;
        apply(cm(16'd55, 5'b10000));
        tick();
        apply(cm(16'd300, 5'b01000));
        #6;
        rst_n = 1'b0;
        exp_q.push_back(ob(16'h0000, 5'b10000));
        #1;
        got  = sample();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_mid_call: got pc=%h fl=%b want pc=%h fl=%b", got.pc, got.fl, want.pc, want.fl);
        end
        @(posedge clk);
        #3;
        apply(cm(16'd0, 5'b00000));
        rst_n = 1'b1;
        exp_q.push_back(ob(16'h0000, 5'b10000));
        tick();
        got  = sample();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_release: got pc=%h fl=%b want pc=%h fl=%b", got.pc, got.fl, want.pc, want.fl);
        end
        apply(cm(16'd0, 5'b00100));
        exp_q.push_back(ob(16'h0000, 5'b10010));
        tick();
        got  = sample();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_no_push: got pc=%h fl=%b want pc=%h fl=%b", got.pc, got.fl, want.pc, want.fl);
        end
        apply(cm(16'd0, 5'b00000));
    endtask

    initial begin
        rst_n = 1'b0;
        apply(cm(16'd0, 5'b00000));
        tick();
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        test_reset();
        test_load_inc();
        test_call_ret();
        test_overflow();
        test_underflow_wrap();
        test_reset_mid_call();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
